add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter SHALL be: DATAWIDTH, 16, width of each operand and of the sum.
REQ-002 Port SHALL be: Clk  input  1  single rising-edge clock for all state.
REQ-003 Port SHALL be: Rst  input  1  asynchronous, active-high reset.
REQ-004 Port SHALL be: req  input  4  per-requester add request, bit i = requester i.
REQ-005 Port SHALL be: a_bus  input  4*DATAWIDTH  operand a, requester i in bits [i*DATAWIDTH +: DATAWIDTH].
REQ-006 Port SHALL be: b_bus  input  4*DATAWIDTH  operand b, same packing as a_bus.
REQ-007 Port SHALL be: gnt  output  4  one-hot registered grant pulse, meaning operands captured.
REQ-008 Port SHALL be: sum  output  DATAWIDTH  registered result of the granted add.
REQ-009 Port SHALL be: sum_id  output  2  index of the requester owning sum.
REQ-010 Port SHALL be: sum_valid  output  1  sum/sum_id valid, held until accepted.
REQ-011 Port SHALL be: sum_ready  input  1  consumer accepts the result.

Function
REQ-012 The block SHALL share one DATAWIDTH adder among 4 requesters via FSM states IDLE, EXEC, DONE.
REQ-013 IDLE: at a rising edge with req != 0, the block SHALL select a winner w, capture a_bus/b_bus slice w, set sum_id=w, and enter EXEC; with req == 0 it SHALL stay in IDLE.
REQ-014 Winner selection SHALL be round-robin: first set req bit scanning upward from pointer ptr, wrapping 3->0.
REQ-015 gnt[w] SHALL be 1 for exactly the single EXEC cycle; gnt SHALL be 0 in all other states.
REQ-016 EXEC: at the next edge the block SHALL register sum = (a + b) mod 2^DATAWIDTH, set sum_valid=1, and enter DONE.
REQ-017 DONE: sum, sum_id and sum_valid SHALL hold stable until an edge with sum_ready=1; at that edge sum_valid SHALL clear, ptr SHALL become (w+1) mod 4, and the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be 2 cycles from the acceptance edge to sum_valid=1; minimum issue interval 3 cycles.
REQ-019 sum_ready SHALL be ignored outside DONE; req and operand changes outside IDLE SHALL have no effect.
REQ-020 A request deasserted before its acceptance edge SHALL be dropped without trace; a request still high in IDLE after its own grant SHALL be re-arbitrated as new.
REQ-021 With all 4 req bits continuously high, grants SHALL occur in order ptr, ptr+1, ... with no requester starved beyond 3 other grants.

Reset
REQ-022 While Rst=1, state SHALL be IDLE, ptr=0, gnt=0, sum=0, sum_id=0, sum_valid=0, and sum_ovf=0 when present.
REQ-023 Rst asserted mid-operation (EXEC or DONE) SHALL discard the captured operation and result immediately, without waiting for Clk.

Configuration
REQ-024 Macro ADD_ARBITER_OVF_EN defined: an extra output sum_ovf (1 bit) SHALL carry the adder carry-out, registered and held with sum.
REQ-025 Macro ADD_ARBITER_OVF_EN undefined: port sum_ovf SHALL be absent and overflow SHALL be silently discarded (sum wraps mod 2^DATAWIDTH).

Verification
REQ-026 After reset, req=4'b0100, a2=5, b2=7 -> gnt=4'b0100 for one cycle; 2 cycles after acceptance sum=12, sum_id=2, sum_valid=1.
REQ-027 req=4'b1111 held, sum_ready=1 -> grant sequence 0,1,2,3,0 with sums matching each slice; gnt never multi-hot.
REQ-028 sum_valid=1 with sum_ready=0 for 10 cycles, req toggling -> sum, sum_id stable and no new gnt until sum_ready=1.
REQ-029 a=16'hFFFF, b=16'h0002 -> sum=16'h0001; with ADD_ARBITER_OVF_EN, sum_ovf=1; without it, no sum_ovf port.
REQ-030 Rst pulsed asynchronously mid-EXEC and mid-DONE -> all outputs 0 immediately, ptr=0, next arbitration starts from requester 0.

Source files
------------

// File: rtl/add_arbiter.sv
// -----------------------------------------------------------------------------
// add_arbiter
//
// Shares one DATAWIDTH-bit adder among four requesters. A round-robin
// arbiter picks a winner in IDLE and captures its operands. The single
// EXEC cycle drives a one-hot grant pulse and performs the add. The result
// is held in DONE until the consumer accepts it.
//
// Optional feature: define ADD_ARBITER_OVF_EN to add the sum_ovf output.
// This output carries the adder carry-out, registered and held with sum.
// Without the macro the carry is dropped and sum wraps mod 2^DATAWIDTH.
//
// Ports
//   Clk        in   rising-edge clock for all state
//   Rst        in   asynchronous, active-high reset
//   req        in   [3:0] per-requester add request
//   a_bus      in   [4*DATAWIDTH-1:0] operand a, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   b_bus      in   [4*DATAWIDTH-1:0] operand b, same packing
//   gnt        out  [3:0] one-hot grant pulse, high for the EXEC cycle only
//   sum        out  [DATAWIDTH-1:0] registered result of the granted add
//   sum_id     out  [1:0] index of the requester owning sum
//   sum_valid  out  sum/sum_id valid, held until accepted
//   sum_ready  in   consumer accepts the result (used in DONE only)
//   sum_ovf    out  adder carry-out (ADD_ARBITER_OVF_EN only)
// -----------------------------------------------------------------------------
module add_arbiter #(
  parameter int DATAWIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [3:0]             req,
  input  logic [4*DATAWIDTH-1:0] a_bus,
  input  logic [4*DATAWIDTH-1:0] b_bus,
  output logic [3:0]             gnt,
  output logic [DATAWIDTH-1:0]   sum,
  output logic [1:0]             sum_id,
  output logic                   sum_valid,
  input  logic                   sum_ready
`ifdef ADD_ARBITER_OVF_EN
  ,
  output logic                   sum_ovf
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           r_ptr;
  logic [DATAWIDTH-1:0] r_a;
  logic [DATAWIDTH-1:0] r_b;
  logic [3:0]           r_gnt;
  logic [DATAWIDTH-1:0] r_sum;
  logic [1:0]           r_sum_id;
  logic                 r_sum_valid;
`ifdef ADD_ARBITER_OVF_EN
  logic                 r_ovf;
`endif

  logic [1:0]           w_win;

  // Round-robin pick: first set req bit at or above r_ptr, wrapping 3->0.
  // The 2-bit index wraps naturally.
  // NOTE: combinational logic uses blocking '='. Every output gets a default
  // first, so no path leaves a latch.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found = 1'b0;
    idx   = r_ptr;
    w_win = r_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = r_ptr + k[1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        w_win = idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking '<='. Every register sits on the
  // async reset so that a reset mid-operation discards work at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_ptr       <= 2'd0;
      r_a         <= '0;
      r_b         <= '0;
      r_gnt       <= 4'd0;
      r_sum       <= '0;
      r_sum_id    <= 2'd0;
      r_sum_valid <= 1'b0;
`ifdef ADD_ARBITER_OVF_EN
      r_ovf       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_a      <= a_bus[w_win*DATAWIDTH +: DATAWIDTH];
            r_b      <= b_bus[w_win*DATAWIDTH +: DATAWIDTH];
            r_sum_id <= w_win;
            // The grant is registered, so it is visible exactly during EXEC.
            r_gnt    <= 4'b0001 << w_win;
            r_state  <= EXEC;
          end
        end
        EXEC: begin
`ifdef ADD_ARBITER_OVF_EN
          {r_ovf, r_sum} <= {1'b0, r_a} + {1'b0, r_b};
`else
          r_sum          <= r_a + r_b;
`endif
          r_sum_valid <= 1'b1;
          r_gnt       <= 4'd0;
          r_state     <= DONE;
        end
        DONE: begin
          if (sum_ready) begin
            r_sum_valid <= 1'b0;
            r_ptr       <= r_sum_id + 2'd1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_gnt       <= 4'd0;
          r_sum_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sum       = r_sum;
  assign sum_id    = r_sum_id;
  assign sum_valid = r_sum_valid;
`ifdef ADD_ARBITER_OVF_EN
  assign sum_ovf   = r_ovf;
`endif

endmodule

// File: tb/tb_add_arbiter.sv
// -----------------------------------------------------------------------------
// tb_add_arbiter
//
// Directed testbench for add_arbiter with DATAWIDTH = 16. It covers reset
// values, a single add, hold under backpressure, asynchronous reset in EXEC
// and in DONE, and the round-robin order under full load.
// -----------------------------------------------------------------------------
module tb_add_arbiter;

  localparam int DW = 16;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [3:0]    req;
  logic [4*DW-1:0] a_bus;
  logic [4*DW-1:0] b_bus;
  logic [3:0]    gnt;
  logic [DW-1:0] sum;
  logic [1:0]    sum_id;
  logic          sum_valid;
  logic          sum_ready;
`ifdef ADD_ARBITER_OVF_EN
  logic          sum_ovf;
`endif

  int checks = 0;
  int errors = 0;

  add_arbiter #(.DATAWIDTH(DW)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req       (req),
    .a_bus     (a_bus),
    .b_bus     (b_bus),
    .gnt       (gnt),
    .sum       (sum),
    .sum_id    (sum_id),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready)
`ifdef ADD_ARBITER_OVF_EN
    ,
    .sum_ovf   (sum_ovf)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] e_gnt, input logic [DW-1:0] e_sum,
                            input logic [1:0] e_id, input logic e_valid);
    check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
    check({tag, ".sum"},       32'(sum),       32'(e_sum));
    check({tag, ".sum_id"},    32'(sum_id),    32'(e_id));
    check({tag, ".sum_valid"}, 32'(sum_valid), 32'(e_valid));
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Operands per slice: 0: 1234+1111=2345, 1: FFFF+0002=0001 (carry),
  // 2: 5+7=12, 3: 8000+8000=0000 (carry)
  localparam logic [4*DW-1:0] A_INIT = {16'h8000, 16'h0005, 16'hFFFF, 16'h1234};
  localparam logic [4*DW-1:0] B_INIT = {16'h8000, 16'h0007, 16'h0002, 16'h1111};

  logic [1:0]    seq_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [DW-1:0] seq_sum [5] = '{16'h2345, 16'h0001, 16'h000C, 16'h0000, 16'h2345};
`ifdef ADD_ARBITER_OVF_EN
  logic          seq_ovf [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif

  initial begin
    Rst       = 1'b1;
    req       = 4'd0;
    a_bus     = A_INIT;
    b_bus     = B_INIT;
    sum_ready = 1'b0;

    // Reset state
    #2;
    expect_out("reset", 4'd0, 16'd0, 2'd0, 1'b0);
`ifdef ADD_ARBITER_OVF_EN
    check("reset.sum_ovf", 32'(sum_ovf), 32'd0);
`endif
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    // Single request from requester 2: 5 + 7
    req = 4'b0100;
    tick();
    expect_out("r2_grant", 4'b0100, 16'd0, 2'd2, 1'b0);
    req = 4'd0;
    tick();
    expect_out("r2_result", 4'd0, 16'd12, 2'd2, 1'b1);

    // Backpressure: the result holds while req and operands change
    for (int i = 0; i < 10; i++) begin
      req   = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      a_bus = ~A_INIT;
      b_bus = A_INIT;
      tick();
      expect_out($sformatf("hold%0d", i), 4'd0, 16'd12, 2'd2, 1'b1);
    end
    a_bus     = A_INIT;
    b_bus     = B_INIT;
    req       = 4'd0;
    sum_ready = 1'b1;
    tick();
    expect_out("accept", 4'd0, 16'd12, 2'd2, 1'b0);
    sum_ready = 1'b0;
    tick();
    expect_out("idle_no_req", 4'd0, 16'd12, 2'd2, 1'b0);

    // The pointer is now 3, so requester 3 wins. Reset is pulsed mid-EXEC.
    req = 4'b1001;
    tick();
    expect_out("r3_grant", 4'b1000, 16'd12, 2'd3, 1'b0);
    req = 4'd0;
    #2 Rst = 1'b1;
    #1;
    expect_out("rst_exec", 4'd0, 16'd0, 2'd0, 1'b0);
    #1 Rst = 1'b0;

    // The pointer returns to 0 after reset. Reset is pulsed mid-DONE.
    req = 4'b1111;
    tick();
    expect_out("post_rst_grant", 4'b0001, 16'd0, 2'd0, 1'b0);
    tick();
    expect_out("pre_rst_done", 4'd0, 16'h2345, 2'd0, 1'b1);
    #2 Rst = 1'b1;
    #1;
    expect_out("rst_done", 4'd0, 16'd0, 2'd0, 1'b0);
`ifdef ADD_ARBITER_OVF_EN
    check("rst_done.sum_ovf", 32'(sum_ovf), 32'd0);
`endif
    #1 Rst = 1'b0;

    // Full load with sum_ready held high. It is ignored in EXEC.
    sum_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      expect_out($sformatf("rr%0d_grant", n), 4'b0001 << seq_id[n],
                 (n == 0) ? 16'd0 : seq_sum[n-1], seq_id[n], 1'b0);
      tick();
      expect_out($sformatf("rr%0d_result", n), 4'd0, seq_sum[n], seq_id[n], 1'b1);
`ifdef ADD_ARBITER_OVF_EN
      check($sformatf("rr%0d_ovf", n), 32'(sum_ovf), 32'(seq_ovf[n]));
`endif
      tick();
      expect_out($sformatf("rr%0d_accept", n), 4'd0, seq_sum[n], seq_id[n], 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
